// File: rtl/beam_scan.sv
// -----------------------------------------------------------------------------
// beam_scan
//   Delay-and-sum beam scanner for the microphone-array direction-of-arrival
//   path. On an accepted start it latches one complex FFT bin per microphone
//   and a detection threshold. For every steering vector it accumulates the
//   coefficient x spectrum products over all microphones, squares the
//   resulting complex sum into a power, and tracks the strongest beam. At the
//   end of the scan it publishes the winning beam, its angle, its power and a
//   threshold-detect flag. Coefficients come from an external synchronous ROM
//   with a read latency of exactly one cycle.
//
// Ports
//   clk         : clock
//   reset       : synchronous, active-high reset
//   start       : one-cycle scan request, only honoured in IDLE
//   spec_in     : N_MICS complex bins, mic m at [(m+1)*2*DW-1 -: 2*DW],
//                 real in the upper half, imag in the lower half
//   pwr_thresh  : detection threshold, latched with spec_in
//   coef_addr   : ROM address, beam*N_MICS + mic (registered)
//   coef_q      : ROM data, real upper half, valid one cycle after coef_addr
//   busy        : high from the cycle after start until the done cycle
//   done        : one-cycle pulse when the result outputs update
//   best_beam   : index of the maximum-power beam
//   doa         : ANG_START + ANG_STEP*best_beam, signed degrees
//   best_pwr    : power of best_beam
//   detect      : best_pwr >= latched threshold
// -----------------------------------------------------------------------------
module beam_scan #(
    parameter int N_MICS    = 4,
    parameter int N_BEAMS   = 13,
    parameter int DW        = 14,
    parameter int CW        = 14,
    parameter int ANG_START = -90,
    parameter int ANG_STEP  = 15,
    localparam int P        = DW + CW + 1,
    localparam int A        = P + $clog2(N_MICS),
    localparam int PW       = 2 * A + 1,
    localparam int BW       = $clog2(N_BEAMS),
    localparam int AW       = $clog2(N_BEAMS * N_MICS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N_MICS*2*DW-1:0]   spec_in,
    input  logic [PW-1:0]            pwr_thresh,
    output logic [AW-1:0]            coef_addr,
    input  logic [2*CW-1:0]          coef_q,
    output logic                     busy,
    output logic                     done,
    output logic [BW-1:0]            best_beam,
    output logic signed [7:0]        doa,
    output logic [PW-1:0]            best_pwr,
    output logic                     detect
);

    // Mic counter must be at least one bit wide even for a single microphone.
    localparam int MW = (N_MICS > 1) ? $clog2(N_MICS) : 1;

    localparam logic [MW-1:0] MIC_LAST_C  = MW'(N_MICS - 1);
    localparam logic [BW-1:0] BEAM_LAST_C = BW'(N_BEAMS - 1);

    // Angle arithmetic is carried at 16 bits and truncated to 8 on output.
    localparam logic [15:0] ANG0_C     = 16'(ANG_START);
    localparam logic [15:0] ANG_STEP_C = 16'(ANG_STEP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ACC   = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state_r;
    logic [N_MICS*2*DW-1:0]   spec_r;
    logic [PW-1:0]            thresh_r;
    logic [MW-1:0]            mic_r;
    logic [BW-1:0]            beam_r;
    logic signed [A-1:0]      acc_re_r;
    logic signed [A-1:0]      acc_im_r;
    logic [PW-1:0]            max_pwr_r;
    logic [BW-1:0]            max_beam_r;

    logic [2*DW-1:0]          spec_sel_s;
    logic signed [P-1:0]      ar_s;
    logic signed [P-1:0]      ai_s;
    logic signed [P-1:0]      br_s;
    logic signed [P-1:0]      bi_s;
    logic signed [P-1:0]      prod_re_s;
    logic signed [P-1:0]      prod_im_s;
    logic signed [A-1:0]      acc_re_nxt_s;
    logic signed [A-1:0]      acc_im_nxt_s;
    logic signed [PW-1:0]     sq_re_s;
    logic signed [PW-1:0]     sq_im_s;
    logic [PW-1:0]            pwr_s;
    logic                     upd_s;
    logic [PW-1:0]            fin_pwr_s;
    logic [BW-1:0]            fin_beam_s;
    logic [15:0]              fin_beam_ext_s;

    // Select the current microphone's bin and sign-extend all operands to P bits.
    always_comb begin
        spec_sel_s = spec_r[int'(mic_r) * (2 * DW) +: 2 * DW];
        ar_s       = {{(P - CW){coef_q[2*CW-1]}}, coef_q[2*CW-1:CW]};
        ai_s       = {{(P - CW){coef_q[CW-1]}},   coef_q[CW-1:0]};
        br_s       = {{(P - DW){spec_sel_s[2*DW-1]}}, spec_sel_s[2*DW-1:DW]};
        bi_s       = {{(P - DW){spec_sel_s[DW-1]}},   spec_sel_s[DW-1:0]};
    end

    // Full-precision complex multiply and accumulate for the ACC cycle.
    always_comb begin
        prod_re_s    = (ar_s * br_s) - (ai_s * bi_s);
        prod_im_s    = (ar_s * bi_s) + (ai_s * br_s);
        acc_re_nxt_s = acc_re_r + {{(A - P){prod_re_s[P-1]}}, prod_re_s};
        acc_im_nxt_s = acc_im_r + {{(A - P){prod_im_s[P-1]}}, prod_im_s};
    end

    // Beam power from the accumulator registers; PW bits hold it exactly.
    always_comb begin
        sq_re_s = {{(PW - A){acc_re_r[A-1]}}, acc_re_r};
        sq_im_s = {{(PW - A){acc_im_r[A-1]}}, acc_im_r};
        pwr_s   = (sq_re_s * sq_re_s) + (sq_im_s * sq_im_s);
    end

    // Running-max update: beam 0 always wins, later beams only if strictly larger.
    always_comb begin
        upd_s = (beam_r == {BW{1'b0}}) || (pwr_s > max_pwr_r);
        if (upd_s) begin
            fin_pwr_s  = pwr_s;
            fin_beam_s = beam_r;
        end else begin
            fin_pwr_s  = max_pwr_r;
            fin_beam_s = max_beam_r;
        end
        fin_beam_ext_s = {{(16 - BW){1'b0}}, fin_beam_s};
    end

    // Scan sequencer: one FETCH/ACC pair per mic, one CMP per beam, then DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            spec_r     <= {(N_MICS * 2 * DW){1'b0}};
            thresh_r   <= {PW{1'b0}};
            mic_r      <= {MW{1'b0}};
            beam_r     <= {BW{1'b0}};
            acc_re_r   <= {A{1'b0}};
            acc_im_r   <= {A{1'b0}};
            max_pwr_r  <= {PW{1'b0}};
            max_beam_r <= {BW{1'b0}};
            coef_addr  <= {AW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            best_beam  <= {BW{1'b0}};
            doa        <= ANG0_C[7:0];
            best_pwr   <= {PW{1'b0}};
            detect     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        spec_r     <= spec_in;
                        thresh_r   <= pwr_thresh;
                        mic_r      <= {MW{1'b0}};
                        beam_r     <= {BW{1'b0}};
                        acc_re_r   <= {A{1'b0}};
                        acc_im_r   <= {A{1'b0}};
                        max_pwr_r  <= {PW{1'b0}};
                        max_beam_r <= {BW{1'b0}};
                        coef_addr  <= {AW{1'b0}};
                        busy       <= 1'b1;
                        state_r    <= S_FETCH;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    // coef_addr already holds beam*N_MICS+mic; ROM answers next cycle.
                    state_r <= S_ACC;
                end
                S_ACC: begin
                    acc_re_r <= acc_re_nxt_s;
                    acc_im_r <= acc_im_nxt_s;
                    if (mic_r == MIC_LAST_C) begin
                        state_r   <= S_CMP;
                    end else begin
                        mic_r     <= mic_r + 1'b1;
                        coef_addr <= coef_addr + 1'b1;
                        state_r   <= S_FETCH;
                    end
                end
                S_CMP: begin
                    max_pwr_r  <= fin_pwr_s;
                    max_beam_r <= fin_beam_s;
                    if (beam_r == BEAM_LAST_C) begin
                        // Results become visible during the DONE cycle itself.
                        best_beam <= fin_beam_s;
                        doa       <= 8'(ANG0_C + (ANG_STEP_C * fin_beam_ext_s));
                        best_pwr  <= fin_pwr_s;
                        detect    <= (fin_pwr_s >= thresh_r);
                        done      <= 1'b1;
                        state_r   <= S_DONE;
                    end else begin
                        beam_r    <= beam_r + 1'b1;
                        mic_r     <= {MW{1'b0}};
                        acc_re_r  <= {A{1'b0}};
                        acc_im_r  <= {A{1'b0}};
                        coef_addr <= coef_addr + 1'b1;
                        state_r   <= S_FETCH;
                    end
                end
                S_DONE: begin
                    // start is not looked at here; the next one is taken in IDLE.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beam_scan.sv
// -----------------------------------------------------------------------------
// tb_beam_scan
//   Self-checking bench for beam_scan. A behavioural model computes each
//   scan's result directly from the ROM image and latched spectrum with plain
//   integer arithmetic, and a cycle-count model predicts busy/done. A single
//   compare process checks every DUT output against the model on each falling
//   edge; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_beam_scan;

    localparam int N_MICS    = 4;
    localparam int N_BEAMS   = 13;
    localparam int DW        = 14;
    localparam int CW        = 14;
    localparam int ANG_START = -90;
    localparam int ANG_STEP  = 15;
    localparam int P         = DW + CW + 1;
    localparam int A         = P + $clog2(N_MICS);
    localparam int PW        = 2 * A + 1;
    localparam int BW        = $clog2(N_BEAMS);
    localparam int AW        = $clog2(N_BEAMS * N_MICS);
    localparam int LAT       = N_BEAMS * (2 * N_MICS + 1) + 1;

    typedef struct packed {
        logic [BW-1:0] beam;
        logic [PW-1:0] pwr;
    } res_t;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [N_MICS*2*DW-1:0] spec_in;
    logic [PW-1:0]          pwr_thresh;
    logic [AW-1:0]          coef_addr;
    logic [2*CW-1:0]        coef_q;
    logic                   busy;
    logic                   done;
    logic [BW-1:0]          best_beam;
    logic [7:0]             doa;
    logic [PW-1:0]          best_pwr;
    logic                   detect;

    logic [2*CW-1:0] rom [0:N_BEAMS*N_MICS-1];

    int n_cmp = 0;
    int n_mis = 0;
    logic chk_en = 1'b0;

    // model state
    logic          m_busy;
    logic          m_done;
    int            m_cnt;
    res_t          m_pend;
    logic [PW-1:0] m_thr;
    logic [BW-1:0] e_beam;
    logic [7:0]    e_doa;
    logic [PW-1:0] e_pwr;
    logic          e_det;

    beam_scan #(
        .N_MICS(N_MICS), .N_BEAMS(N_BEAMS), .DW(DW), .CW(CW),
        .ANG_START(ANG_START), .ANG_STEP(ANG_STEP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .spec_in(spec_in),
        .pwr_thresh(pwr_thresh), .coef_addr(coef_addr), .coef_q(coef_q),
        .busy(busy), .done(done), .best_beam(best_beam), .doa(doa),
        .best_pwr(best_pwr), .detect(detect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of latency.
    always @(posedge clk) coef_q <= rom[coef_addr];

    function automatic logic [7:0] doa_of(input logic [BW-1:0] b);
        int d;
        d = ANG_START + ANG_STEP * int'(b);
        return d[7:0];
    endfunction

    // Direct evaluation of every beam's power and the strongest beam.
    function automatic res_t model_scan(input logic [N_MICS*2*DW-1:0] sp);
        longint re, im, p, bestp, ar, ai, br, bi;
        int bb;
        logic [2*CW-1:0] c;
        res_t r;
        bestp = 0;
        bb = 0;
        for (int b = 0; b < N_BEAMS; b++) begin
            re = 0;
            im = 0;
            for (int m = 0; m < N_MICS; m++) begin
                c  = rom[b * N_MICS + m];
                ar = longint'($signed(c[2*CW-1:CW]));
                ai = longint'($signed(c[CW-1:0]));
                br = longint'($signed(sp[m*2*DW+DW +: DW]));
                bi = longint'($signed(sp[m*2*DW +: DW]));
                re += ar * br - ai * bi;
                im += ar * bi + ai * br;
            end
            p = re * re + im * im;
            if (b == 0 || p > bestp) begin
                bestp = p;
                bb = b;
            end
        end
        r.beam = bb[BW-1:0];
        r.pwr  = bestp[PW-1:0];
        return r;
    endfunction

    // Cycle-count model: result published LAT cycles after the start edge.
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            e_beam <= '0;
            e_doa  <= doa_of('0);
            e_pwr  <= '0;
            e_det  <= 1'b0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= model_scan(spec_in);
                m_thr  <= pwr_thresh;
                m_busy <= 1'b1;
                m_cnt  <= 1;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == LAT - 1) begin
                m_done <= 1'b1;
                e_beam <= m_pend.beam;
                e_doa  <= doa_of(m_pend.beam);
                e_pwr  <= m_pend.pwr;
                e_det  <= (m_pend.pwr >= m_thr);
            end else if (m_cnt == LAT) begin
                m_done <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",      64'(busy),      64'(m_busy));
            check("done",      64'(done),      64'(m_done));
            check("best_beam", 64'(best_beam), 64'(e_beam));
            check("doa",       64'(doa),       64'(e_doa));
            check("best_pwr",  64'(best_pwr),  64'(e_pwr));
            check("detect",    64'(detect),    64'(e_det));
        end
    end

    // mode 0: quiet, mode 1: random start/input noise, mode 2: start at cycles 10 and 60
    task automatic run_scan(input int mode, output int lat, output int extra);
        logic got;
        got = 1'b0;
        lat = 0;
        extra = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (mode == 1) begin
                start = ($urandom_range(0, 7) == 0);
                for (int m = 0; m < N_MICS; m++) spec_in[m*2*DW +: 2*DW] = 28'($urandom);
                pwr_thresh = 63'({$urandom, $urandom});
            end else begin
                start = (mode == 2) && (i == 10 || i == 60);
            end
            if (done) begin
                lat = i;
                got = 1'b1;
                // Holding start through the DONE edge must not launch a scan.
                if (mode == 1) start = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) extra++;
        end
    endtask

    task automatic set_spec_all(input logic [2*DW-1:0] v);
        for (int m = 0; m < N_MICS; m++) spec_in[m*2*DW +: 2*DW] = v;
    endtask

    task automatic set_rom_all(input logic [2*CW-1:0] v);
        for (int i = 0; i < N_BEAMS * N_MICS; i++) rom[i] = v;
    endtask

    initial begin
        int   lat;
        int   extra;
        int   nd;
        res_t r;

        reset = 1'b1;
        start = 1'b0;
        spec_in = '0;
        pwr_thresh = '0;
        set_rom_all('0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy),      64'd0);
        check("rst_done", 64'(done),      64'd0);
        check("rst_doa",  64'(doa),       64'hA6);
        check("rst_pwr",  64'(best_pwr),  64'd0);
        check("rst_addr", 64'(coef_addr), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Uniform power: every beam 10000, lowest index wins.
        set_rom_all({14'd1, 14'd0});
        set_spec_all('0);
        spec_in[2*DW-1:0] = {14'd100, 14'd0};
        pwr_thresh = '0;
        run_scan(0, lat, extra);
        check("uni_latency", 64'(lat),       64'd118);
        check("uni_beam",    64'(best_beam), 64'd0);
        check("uni_doa",     64'(doa),       64'hA6);
        check("uni_pwr",     64'(best_pwr),  64'd10000);
        check("uni_extra",   64'(extra),     64'd0);

        // Steered peak on beam 7, threshold exactly at the power.
        set_rom_all('0);
        for (int m = 0; m < N_MICS; m++) rom[7 * N_MICS + m] = {14'd1, 14'd0};
        set_spec_all({14'd50, 14'h3FEC});
        pwr_thresh = 63'd46400;
        run_scan(0, lat, extra);
        check("steer_beam", 64'(best_beam), 64'd7);
        check("steer_doa",  64'(doa),       64'h0F);
        check("steer_pwr",  64'(best_pwr),  64'd46400);
        check("thr_eq_det", 64'(detect),    64'd1);
        pwr_thresh = 63'd46401;
        run_scan(0, lat, extra);
        check("thr_gt_det", 64'(detect),    64'd0);

        // Extreme operands: each product is 0 + 2^27 j.
        set_rom_all({14'h2000, 14'h2000});
        set_spec_all({14'h2000, 14'h2000});
        pwr_thresh = '0;
        run_scan(0, lat, extra);
        check("ext_pwr",  64'(best_pwr),  64'h0400_0000_0000_0000);
        check("ext_beam", 64'(best_beam), 64'd0);

        // start pulses during a scan are ignored.
        set_rom_all({14'd1, 14'd0});
        set_spec_all('0);
        spec_in[2*DW-1:0] = {14'd100, 14'd0};
        run_scan(2, lat, extra);
        check("bs_latency", 64'(lat),   64'd118);
        check("bs_extra",   64'(extra), 64'd0);

        // Mid-scan reset at cycle 50, then a clean rerun.
        set_rom_all('0);
        for (int m = 0; m < N_MICS; m++) rom[7 * N_MICS + m] = {14'd1, 14'd0};
        set_spec_all({14'd50, 14'h3FEC});
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_busy", 64'(busy),      64'd0);
        check("mr_done", 64'(done),      64'd0);
        check("mr_beam", 64'(best_beam), 64'd0);
        check("mr_doa",  64'(doa),       64'hA6);
        check("mr_pwr",  64'(best_pwr),  64'd0);
        check("mr_det",  64'(detect),    64'd0);
        nd = 0;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("mr_no_done", 64'(nd), 64'd0);
        run_scan(0, lat, extra);
        check("mr_latency", 64'(lat),       64'd118);
        check("mr_beam7",   64'(best_beam), 64'd7);

        // Randomized scans with input noise during the scan.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N_BEAMS * N_MICS; i++) rom[i] = 28'($urandom);
            for (int m = 0; m < N_MICS; m++) spec_in[m*2*DW +: 2*DW] = 28'($urandom);
            r = model_scan(spec_in);
            case ($urandom_range(0, 2))
                0:       pwr_thresh = r.pwr;
                1:       pwr_thresh = r.pwr + 63'd1;
                default: pwr_thresh = 63'({$urandom, $urandom});
            endcase
            run_scan(1, lat, extra);
            check("rnd_latency", 64'(lat),   64'(LAT));
            check("rnd_extra",   64'(extra), 64'd0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
